// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list sequencer.
// Holds the opcode values, command word field positions and the FSM state encoding.
// Helper functions extract the command fields so that no other file repeats the bit slicing.
package vector_pkg;

  localparam int CMD_W = 26;

  // Command word layout: [25:24] op, [23:12] x, [11:0] y
  localparam int OP_MSB = 25;
  localparam int OP_LSB = 24;
  localparam int X_MSB  = 23;
  localparam int X_LSB  = 12;
  localparam int Y_MSB  = 11;
  localparam int Y_LSB  = 0;

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAITDATA,
    S_DECODE,
    S_ISSUE,
    S_HOLD,
    S_WAITRDY,
    S_SETTLE,
    S_PARK,
    S_FRAMEWAIT
  } state_t;

  function automatic logic [1:0] cmd_op(input logic [CMD_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [11:0] cmd_x(input logic [CMD_W-1:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [11:0] cmd_y(input logic [CMD_W-1:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Bus bundle between the sequencer, its display-list RAM and the vector controller.
// RAM side: mem_rd/mem_addr out, mem_data back one cycle after mem_rd.
// Controller side: x/y target with jump/draw pulses out, ctrl_ready level back.
interface vector_sequencer_if #(
  parameter int ADDR_W = 10
);
  import vector_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [CMD_W-1:0]  mem_data;
  logic              ctrl_ready;
  logic [11:0]       x;
  logic [11:0]       y;
  logic              jump;
  logic              draw;

  // Sequencer side
  modport master (
    output mem_rd, mem_addr, x, y, jump, draw,
    input  mem_data, ctrl_ready
  );

  // RAM + controller side
  modport slave (
    input  mem_rd, mem_addr, x, y, jump, draw,
    output mem_data, ctrl_ready
  );

endinterface

// File: rtl/seq_delay_counter.sv
// Loadable down-counter used for the post-pulse holdoff and the post-jump beam settle dwell.
// Ports: clk, reset (async active-low), load_i/load_val_i (load count), en_i (count), done_o.
// done_o is high on the last counted cycle, so a load of N keeps the owner waiting exactly N cycles (min 1).
module seq_delay_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/vector_sequencer.sv
// Display-list sequencer: fetches commands, issues x/y with jump/draw pulses, settles, parks, restarts per frame tick.
// Latency: pulse appears 4 cycles after mem_rd (fetch, data, decode, issue); x/y/jump/draw/busy/frame_done are registered.
// Backpressure: waits on ctrl_ready before each pulse and again after the holdoff window; ready is ignored during holdoff.
// Ports: clk, reset (async active-low), enable, frame_tick, base_addr, bus (RAM + controller), busy, frame_done, overrun.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          HOLDOFF = 2,
  parameter int          SETTLE  = 64,
  parameter logic [11:0] PARK_X  = 12'd2048,
  parameter logic [11:0] PARK_Y  = 12'd2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_tick,
  input  logic [ADDR_W-1:0] base_addr,
  vector_sequencer_if.master bus,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int CNT_MAX = (HOLDOFF > SETTLE) ? HOLDOFF : SETTLE;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [11:0]        x_q, x_d;
  logic [11:0]        y_q, y_d;
  logic               jump_q, jump_d;
  logic               draw_q, draw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_en;
  logic               cnt_done;

  seq_delay_counter #(.W(CNT_W)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .done_o     (cnt_done)
  );

  assign cnt_en = (state_q == S_HOLD) || (state_q == S_SETTLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    x_d       = x_q;
    y_d       = y_q;
    jump_d    = 1'b0;
    draw_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (frame_tick & busy_q);
    cnt_load  = 1'b0;
    cnt_val   = CNT_W'(HOLDOFF);

    case (state_q)
      S_IDLE, S_FRAMEWAIT: begin
        // A tick coinciding with the frame_done pulse is dropped, not queued.
        if (enable && frame_tick && !done_q) begin
          addr_d  = base_addr;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAITDATA;
      end
      S_WAITDATA: begin
        cmd_d   = bus.mem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cmd_op(cmd_q))
          OP_NOP: begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
          OP_END:  state_d = S_PARK;
          default: state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (bus.ctrl_ready) begin
          x_d      = cmd_x(cmd_q);
          y_d      = cmd_y(cmd_q);
          jump_d   = (cmd_op(cmd_q) == OP_JUMP);
          draw_d   = (cmd_op(cmd_q) == OP_DRAW);
          addr_d   = addr_q + 1'b1;
          cnt_load = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_PARK: begin
        // cmd_q keeps the END word, which marks this handshake as the park jump.
        if (bus.ctrl_ready) begin
          x_d      = PARK_X;
          y_d      = PARK_Y;
          jump_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          state_d = S_WAITRDY;
        end
      end
      S_WAITRDY: begin
        if (bus.ctrl_ready) begin
          case (cmd_op(cmd_q))
            OP_END: begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_FRAMEWAIT;
            end
            OP_JUMP: begin
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(SETTLE);
              state_d  = S_SETTLE;
            end
            default: begin
              if (enable) begin
                state_d = S_FETCH;
              end else begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end
      S_SETTLE: begin
        if (cnt_done) begin
          if (enable) begin
            state_d = S_FETCH;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cmd_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      jump_q    <= 1'b0;
      draw_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      jump_q    <= jump_d;
      draw_q    <= draw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.mem_rd   = (state_q == S_FETCH);
  assign bus.mem_addr = addr_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.jump     = jump_q;
  assign bus.draw     = draw_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: directed display lists, a list-walking model of
// the expected pulse/fetch/frame_done stream, and a per-cycle compare process.
module tb_vector_sequencer;
  import vector_pkg::*;

  localparam int HOLDOFF = 2;
  localparam int SETTLE  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] base_addr = '0;
  logic       busy, frame_done, overrun;

  vector_sequencer_if #(.ADDR_W(10)) bus ();

  vector_sequencer #(
    .ADDR_W(10), .HOLDOFF(HOLDOFF), .SETTLE(SETTLE),
    .PARK_X(12'd2048), .PARK_Y(12'd2048)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (enable),
    .frame_tick (frame_tick),
    .base_addr  (base_addr),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous display-list RAM
  logic [25:0] mem [0:1023];
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        is_draw;
    logic [11:0] x;
    logic [11:0] y;
  } pulse_t;

  pulse_t     exp_pulse[$];
  logic [9:0] exp_addr[$];
  int         exp_done = 0;

  int pulse_cyc[$];
  int rd_cyc[$];
  int n_draw = 0;
  int done_cnt = 0;
  logic [11:0] last_x = '0, last_y = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [25:0] mk(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y);
    return {op, x, y};
  endfunction

  function automatic pulse_t mkp(input logic d, input logic [11:0] x, input logic [11:0] y);
    pulse_t p;
    p.is_draw = d;
    p.x = x;
    p.y = y;
    return p;
  endfunction

  // Walk the list as the sequencer should: every visited word is one fetch; JUMP/DRAW give a pulse;
  // END gives the park jump and one frame_done. 'limit' stops the walk after that many list pulses.
  task automatic build_expect(input int base, input int limit);
    int a;
    int np;
    logic [25:0] w;
    a = base;
    np = 0;
    for (int g = 0; g < 4096; g++) begin
      w = mem[a];
      exp_addr.push_back(10'(a));
      if (w[25:24] == OP_NOP) begin
        a = (a + 1) % 1024;
      end else if (w[25:24] == OP_END) begin
        exp_pulse.push_back(mkp(1'b0, 12'd2048, 12'd2048));
        exp_done++;
        break;
      end else begin
        exp_pulse.push_back(mkp(w[25:24] == OP_DRAW, w[23:12], w[11:0]));
        np++;
        a = (a + 1) % 1024;
        if (np >= limit) break;
      end
    end
  endtask

  // Compare process: checks every output event against the model.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_x = '0;
      last_y = '0;
    end else begin
      check("jump_draw_exclusive", 32'(bus.jump & bus.draw), 0);
      if (bus.jump || bus.draw) begin : pulse_chk
        pulse_t p;
        pulse_cyc.push_back(cyc);
        if (bus.draw) n_draw++;
        check("pulse_expected", 32'(exp_pulse.size() > 0), 1);
        if (exp_pulse.size() > 0) begin
          p = exp_pulse.pop_front();
          check("pulse_kind_draw", 32'(bus.draw), 32'(p.is_draw));
          check("pulse_x", 32'(bus.x), 32'(p.x));
          check("pulse_y", 32'(bus.y), 32'(p.y));
        end
        last_x = bus.x;
        last_y = bus.y;
      end else begin
        check("x_hold", 32'(bus.x), 32'(last_x));
        check("y_hold", 32'(bus.y), 32'(last_y));
      end
      if (bus.mem_rd) begin
        rd_cyc.push_back(cyc);
        check("mem_rd_expected", 32'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
      end
      if (frame_done) begin
        done_cnt++;
        check("frame_done_expected", 32'(exp_done > 0), 1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic clear_obs();
    pulse_cyc.delete();
    rd_cyc.delete();
    n_draw = 0;
  endtask

  task automatic tick_frame();
    @(negedge clk); #1;
    frame_tick = 1'b1;
    @(negedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_pulses(input int n, input int limit, input string name);
    for (int i = 0; i < limit && pulse_cyc.size() < n; i++) begin
      @(negedge clk); #1;
    end
    check(name, 32'(pulse_cyc.size() >= n), 1);
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    for (int i = 0; i < limit && done_cnt < target; i++) begin
      @(negedge clk); #1;
    end
    check(name, 32'(done_cnt >= target), 1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_pulses_left"}, 32'(exp_pulse.size()), 0);
    check({name, "_fetches_left"}, 32'(exp_addr.size()), 0);
    check({name, "_done_left"}, 32'(exp_done), 0);
  endtask

  task automatic load_t1_list();
    mem[0] = mk(OP_JUMP, 12'd100, 12'd200);
    mem[1] = mk(OP_DRAW, 12'd300, 12'd400);
    mem[2] = mk(OP_END, 12'd0, 12'd0);
    mem[3] = mk(OP_END, 12'd0, 12'd0);
  endtask

  int rd_before;
  int ready_cyc;
  int done_before;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = mk(OP_END, 12'd0, 12'd0);
    bus.ctrl_ready = 1'b1;
    step(3);

    // Reset values
    check("rst_mem_rd", 32'(bus.mem_rd), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_x", 32'(bus.x), 0);
    check("rst_y", 32'(bus.y), 0);
    check("rst_jump", 32'(bus.jump), 0);
    check("rst_draw", 32'(bus.draw), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    step(2);

    // T1: JUMP(100,200), DRAW(300,400), END with ready tied high
    load_t1_list();
    clear_obs();
    build_expect(0, 1000);
    enable = 1'b1;
    base_addr = 10'd0;
    tick_frame();
    wait_pulses(1, 50, "t1_first_pulse_timeout");
    check("t1_busy_mid", 32'(busy), 1);
    wait_done(1, 400, "t1_done_timeout");
    // A tick in the frame_done cycle is neither an overrun nor a new frame.
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    check("t1_pulse_count", 32'(pulse_cyc.size()), 3);
    check("t1_rd_count", 32'(rd_cyc.size()), 3);
    if (pulse_cyc.size() == 3 && rd_cyc.size() >= 1) begin
      check("t1_rd_to_jump", 32'(pulse_cyc[0] - rd_cyc[0]), 4);
      check("t1_jump_to_draw", 32'(pulse_cyc[1] - pulse_cyc[0]), 71);
      check("t1_draw_to_park", 32'(pulse_cyc[2] - pulse_cyc[1]), 7);
    end
    check("t1_park_x", 32'(bus.x), 2048);
    check("t1_park_y", 32'(bus.y), 2048);
    step(10);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_tick_at_done_no_overrun", 32'(overrun), 0);
    check("t1_tick_at_done_no_fetch", 32'(rd_cyc.size()), 3);
    check_drained("t1");

    // T2: ready withheld for 20 cycles after the draw pulse
    clear_obs();
    build_expect(0, 1000);
    tick_frame();
    wait_pulses(2, 300, "t2_draw_timeout");
    bus.ctrl_ready = 1'b0;
    rd_before = rd_cyc.size();
    step(20);
    check("t2_no_rd_while_not_ready", 32'(rd_cyc.size()), 32'(rd_before));
    check("t2_no_pulse_while_not_ready", 32'(pulse_cyc.size()), 2);
    bus.ctrl_ready = 1'b1;
    ready_cyc = cyc;
    wait_done(2, 100, "t2_done_timeout");
    if (pulse_cyc.size() == 3) check("t2_ready_to_park", 32'(pulse_cyc[2] - ready_cyc), 5);
    step(3);
    check_drained("t2");

    // T3: NOP, NOP, DRAW(5,6), END
    mem[0] = mk(OP_NOP, 12'd7, 12'd7);
    mem[1] = mk(OP_NOP, 12'd8, 12'd8);
    mem[2] = mk(OP_DRAW, 12'd5, 12'd6);
    mem[3] = mk(OP_END, 12'd0, 12'd0);
    clear_obs();
    build_expect(0, 1000);
    tick_frame();
    wait_done(3, 300, "t3_done_timeout");
    check("t3_draw_count", 32'(n_draw), 1);
    check("t3_pulse_count", 32'(pulse_cyc.size()), 2);
    check("t3_rd_count", 32'(rd_cyc.size()), 4);
    step(3);
    check_drained("t3");

    // T4: extra tick mid-frame sets sticky overrun, frame still completes once
    load_t1_list();
    clear_obs();
    build_expect(0, 1000);
    done_before = done_cnt;
    tick_frame();
    wait_pulses(1, 50, "t4_first_pulse_timeout");
    tick_frame();
    check("t4_overrun_set", 32'(overrun), 1);
    check("t4_busy_kept", 32'(busy), 1);
    wait_done(done_before + 1, 400, "t4_done_timeout");
    step(20);
    check("t4_one_frame_done", 32'(done_cnt - done_before), 1);
    check("t4_overrun_sticky", 32'(overrun), 1);
    check_drained("t4");

    // T5: enable dropped during settle after a jump
    mem[0] = mk(OP_JUMP, 12'd10, 12'd20);
    mem[1] = mk(OP_DRAW, 12'd30, 12'd40);
    mem[2] = mk(OP_END, 12'd0, 12'd0);
    clear_obs();
    build_expect(0, 1);
    done_before = done_cnt;
    tick_frame();
    wait_pulses(1, 50, "t5_jump_timeout");
    step(10);
    enable = 1'b0;
    step(40);
    check("t5_busy_during_settle", 32'(busy), 1);
    step(60);
    check("t5_busy_after_stop", 32'(busy), 0);
    check("t5_pulse_count", 32'(pulse_cyc.size()), 1);
    check("t5_rd_count", 32'(rd_cyc.size()), 1);
    check("t5_no_frame_done", 32'(done_cnt - done_before), 0);
    check("t5_overrun_still_sticky", 32'(overrun), 1);
    check_drained("t5");
    enable = 1'b1;

    // T6: list at 1023 wraps to 0
    mem[1023] = mk(OP_JUMP, 12'd1, 12'd1);
    mem[0] = mk(OP_END, 12'd0, 12'd0);
    clear_obs();
    base_addr = 10'd1023;
    build_expect(1023, 1000);
    done_before = done_cnt;
    tick_frame();
    wait_done(done_before + 1, 300, "t6_done_timeout");
    check("t6_rd_count", 32'(rd_cyc.size()), 2);
    check("t6_pulse_count", 32'(pulse_cyc.size()), 2);
    step(3);
    check_drained("t6");

    // Reset asserted in the first HOLD cycle after a jump
    clear_obs();
    build_expect(1023, 1000);
    tick_frame();
    wait_pulses(1, 50, "t6r_jump_timeout");
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_rd", 32'(bus.mem_rd), 0);
    check("rstmid_mem_addr", 32'(bus.mem_addr), 0);
    check("rstmid_x", 32'(bus.x), 0);
    check("rstmid_y", 32'(bus.y), 0);
    check("rstmid_jump", 32'(bus.jump), 0);
    check("rstmid_draw", 32'(bus.draw), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_frame_done", 32'(frame_done), 0);
    check("rstmid_overrun", 32'(overrun), 0);
    exp_pulse.delete();
    exp_addr.delete();
    exp_done = 0;
    step(3);
    rst_n = 1'b1;
    rd_before = rd_cyc.size();
    step(10);
    check("post_reset_idle_no_fetch", 32'(rd_cyc.size()), 32'(rd_before));
    check("post_reset_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Display-list sequencer that sits ahead of the vector control block.
- Fetches 26-bit vector commands from a synchronous display-list RAM and presents x/y with one-cycle jump/draw pulses under the controller's ready handshake.
- Inserts beam-settle dwell after jumps, parks the beam at list end, and restarts the list on each frame tick (refresh scheduler).

Parameters:
- ADDR_W, 10, display-list address width (1024 words).
- HOLDOFF, 2, cycles after a jump/draw pulse during which ctrl_ready is ignored.
- SETTLE, 64, dwell cycles after every JUMP before the next command is fetched.
- PARK_X, 12'd2048, beam x park position at list end.
- PARK_Y, 12'd2048, beam y park position at list end.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  level; 1 = run frames, 0 = stop at next command boundary.
- frame_tick  in  1  one-cycle pulse marking the start of a refresh frame.
- base_addr  in  ADDR_W  list start address, sampled on frame start.
- mem_rd  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  in  26  RAM data, valid exactly 1 cycle after mem_rd.
- ctrl_ready  in  1  controller ready level.
- x  out  12  target x, held stable from pulse until the next pulse.
- y  out  12  target y, held stable from pulse until the next pulse.
- jump  out  1  one-cycle jump pulse.
- draw  out  1  one-cycle draw pulse.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes (after park).
- overrun  out  1  sticky; a frame_tick arrived while busy. Cleared only by reset.

Behaviour:
- Reset values (async): all outputs 0; x=y=0; state IDLE; address register 0.
- Command word: [25:24] op, [23:12] x, [11:0] y.
  - 00 JUMP, 01 DRAW, 10 END, 11 NOP (skipped, no pulse).
- States: IDLE, FETCH, WAITDATA, DECODE, ISSUE, HOLD, WAITRDY, SETTLE, PARK, FRAMEWAIT.
- IDLE: when enable=1 and frame_tick=1:
  - latch base_addr into the address register;
  - set busy=1;
  - go to FETCH.
- FETCH: mem_rd=1 for one cycle at the current address; go to WAITDATA. WAITDATA: capture mem_data; go to DECODE.
- DECODE:
  - NOP: addr+1, go to FETCH.
  - END: go to PARK.
  - JUMP/DRAW: go to ISSUE.
- ISSUE: wait for ctrl_ready=1. In the same cycle:
  - drive x/y from the word;
  - pulse jump or draw for 1 cycle;
  - addr+1;
  - go to HOLD.
  - Pulse latency: ≥3 cycles after mem_rd.
- HOLD: count HOLDOFF cycles, then go to WAITRDY.
- WAITRDY: wait for ctrl_ready=1.
  - After a JUMP, go to SETTLE.
  - After a DRAW, go to FETCH, or IDLE if enable=0.
- SETTLE: count SETTLE cycles, then go to FETCH, or IDLE if enable=0.
- PARK: issue a jump to PARK_X/PARK_Y using the ISSUE/HOLD/WAITRDY handshake (no SETTLE). Then pulse frame_done, set busy=0, go to FRAMEWAIT.
- FRAMEWAIT: behaves as IDLE (the next frame_tick with enable=1 starts a frame).
- Address wrap: addr increments modulo 2^ADDR_W. A list without END wraps and keeps fetching.
  - Any frame_tick during busy sets overrun.
  - The current frame is never aborted by frame_tick.
- enable=0 mid-frame:
  - the in-flight command completes its handshake, including SETTLE;
  - then go to IDLE with busy=0 and no park or frame_done.
- frame_tick together with enable 0→1 in IDLE: the frame starts.
- frame_tick in the exact cycle a frame_done pulse occurs: not overrun; the frame starts next cycle only if the tick is still present (ticks are single-cycle, so it is lost).
- jump and draw are never both high. mem_rd is never high outside FETCH.
- Reset mid-operation: immediate return to reset values; overrun cleared.

Decomposition:
- Shared package (vector_pkg):
  - opcode constants OP_JUMP/OP_DRAW/OP_END/OP_NOP;
  - command field bit positions;
  - state encoding enum.
- One natural sub-module, seq_delay_counter: loadable down-counter with a done flag, reused for HOLD and SETTLE.

Test Plan:
- List @0: JUMP(100,200), DRAW(300,400), END.
  - Frame tick with ctrl_ready tied 1 → jump with x=100,y=200.
  - Then exactly HOLDOFF+SETTLE+… cycles later, draw with x=300,y=400.
  - Then park jump (2048,2048), then frame_done; busy low afterward.
- Same list, ctrl_ready held 0 for 20 cycles after the draw pulse → no further pulse and no mem_rd until ctrl_ready returns.
- List NOP,NOP,DRAW(5,6),END → only one draw pulse (5,6); mem_addr sequence 0,1,2,3.
- Second frame_tick issued mid-frame → overrun=1 sticky; frame still completes with one frame_done; overrun stays 1 until reset.
- enable dropped during the SETTLE after a JUMP → settle completes, state IDLE, busy=0, no park jump, no frame_done.
- base_addr=1023 with list JUMP(1,1)@1023, END@0 → address wraps to 0; park completes. Reset asserted mid-HOLD → all outputs 0 within the same cycle.
